x_23k640_req: RTL and testbench
===============================

// Module: x_23K640_req
// PURPOSE
//  Request/completion buffer directly upstream of x_23K640_data. Queues application rd/wr requests,
//  presents the queue head to the data engine until its single-cycle accept pulse, and captures read
//  completions (single-cycle ready pulse, no backpressure possible) into a response buffer.
//  Read issue is credit-gated so a completion is never dropped.
// PARAMETERS
//  REQ_DEPTH  4  request FIFO entries; power of 2, >=2
//  RSP_DEPTH  4  response FIFO entries when X23K640_RDATA_FIFO_EN defined; power of 2, >=2
// PORTS
//  i_clk          in   1   clock
//  i_rst          in   1   reset, asynchronous, active-high
//  i_req_valid    in   1   app request valid
//  o_req_ready    out  1   request FIFO not full; transfer on valid&ready
//  i_req_rd_n_wr  in   1   1=read, 0=write
//  i_req_addr     in   16  byte address
//  i_req_wdata    in   8   write data (ignored for reads)
//  o_rsp_valid    out  1   read data available
//  i_rsp_ready    in   1   app consumes read data on valid&ready
//  o_rsp_rdata    out  8   read data, oldest first
//  o_eng_valid    out  1   to engine i_valid
//  i_eng_accept   in   1   engine o_accept pulse; pops head
//  o_eng_rd_n_wr  out  1   head rd_n_wr
//  o_eng_addr     out  16  head address
//  o_eng_wdata    out  8   head write data
//  i_eng_ready    in   1   engine o_ready pulse; read data valid this cycle
//  i_eng_rdata    in   8   engine read data
//  o_busy         out  1   request FIFO non-empty | reads outstanding | response buffer non-empty
// BEHAVIOUR
//  Reset: all FIFOs empty, outstanding=0; o_req_ready=1, o_rsp_valid=0, o_eng_valid=0,
//   o_eng_* fields 0, o_rsp_rdata=0, o_busy=0. Reset mid-transfer discards everything.
//  Request FIFO: push on i_req_valid&o_req_ready; o_req_ready=~full (no pop-through when full,
//   even if i_eng_accept same cycle). Simultaneous push/pop when not full: count unchanged.
//  Head fields driven from FIFO head register; stable while o_eng_valid=1 until i_eng_accept.
//  o_eng_valid = ~req_empty & (~head_rd_n_wr | credit>0). Engine only samples in idle/final bit.
//  i_eng_accept while o_eng_valid=0 is a protocol error (assertion); no state change.
//  outstanding (width clog2(CAP)+1): +1 on i_eng_accept of a read, -1 on i_eng_ready;
//   both in one cycle (back-to-back sequential reads) -> unchanged.
//  credit = CAP - (rsp_count + outstanding); CAP = RSP_DEPTH or 1 (see CONFIGURATION).
//  i_eng_ready: push i_eng_rdata into response buffer; guaranteed space by credit.
//   Latency i_eng_ready -> o_rsp_valid = 1 cycle (registered). Push+pop same cycle allowed.
//  Writes produce no completion; ordering strictly FIFO across reads and writes.
//  Pointers wrap modulo depth; full/empty via extra pointer MSB.
// CONFIGURATION
//  X23K640_RDATA_FIFO_EN defined: response buffer = RSP_DEPTH-entry FIFO, CAP=RSP_DEPTH; up to
//   RSP_DEPTH reads may complete while app stalls i_rsp_ready.
//  Not defined: response buffer = single register + valid flag, CAP=1; a new read is not
//   presented while a previous read is outstanding or its data unconsumed. RSP_DEPTH unused.
// STRUCTURE
//  Package x_23K640_pkg: req_t struct {rd_n_wr, addr[15:0], wdata[7:0]}, ADDR_W=16, DATA_W=8.
//  Sub-module x_23K640_fifo (generic sync FIFO: WIDTH, DEPTH, push/pop/full/empty/count),
//   instantiated for requests (req_t) and, with macro, for responses (8 bit).
// TESTING
//  1 Reset, idle -> o_req_ready=1, o_eng_valid=0, o_rsp_valid=0, o_busy=0.
//  2 Push write 0x0010/0xA5 -> o_eng_valid=1, addr=0x0010, wdata=0xA5; accept pulse -> valid=0,
//    no response.
//  3 Push 5 requests with no accept, REQ_DEPTH=4 -> 4 accepted, o_req_ready=0; one accept ->
//    ready=1 next cycle.
//  4 Reads 0x0100,0x0101 back-to-back; accept#2 and ready#1 same cycle -> outstanding stays 1;
//    rdata 0x3C,0xC3 in order on o_rsp_rdata, each 1 cycle after i_eng_ready.
//  5 i_rsp_ready=0, 6 reads queued: macro on -> 4 issued then o_eng_valid=0; macro off -> 1 issued.
//    Release i_rsp_ready -> all data in order.
//  6 Assert i_rst with 2 reads queued, 1 outstanding -> all outputs to reset values immediately.
//  Checkers: head stable while valid; no i_eng_ready when outstanding=0; response never overflows.

Source files
------------

// File: rtl/x_23k640_req_pkg.sv
// Shared types for the 23K640 request/completion buffer.
// Request payload layout and the address/data widths of the SRAM engine interface.
package x_23k640_req_pkg;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 8;

   typedef struct packed {
      logic              rd_n_wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   localparam int unsigned REQ_W = $bits(req_t);

endpackage

// File: rtl/x_23k640_req_fifo.sv
// Generic synchronous FIFO with extra-MSB pointers for full/empty detection.
// Pushes while full and pops while empty are ignored; storage is cleared on reset.
module x_23k640_req_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_rdata,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             push_en, pop_en;

   assign o_empty = (wr_ptr_q == rd_ptr_q);
   assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign o_count = wr_ptr_q - rd_ptr_q;
   assign o_rdata = mem_q[rd_ptr_q[AW-1:0]];

   assign push_en = i_push & ~o_full;
   assign pop_en  = i_pop & ~o_empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         if (push_en) mem_q[wr_ptr_q[AW-1:0]] <= i_wdata;
      end
   end

endmodule

// File: rtl/x_23k640_req.sv
// Request queue and read-completion buffer in front of the 23K640 data engine.
// Define X23K640_RDATA_FIFO_EN for a RSP_DEPTH-deep response FIFO; otherwise a single register.
module x_23k640_req
   import x_23k640_req_pkg::*;
#(
   parameter int unsigned REQ_DEPTH = 4,
   parameter int unsigned RSP_DEPTH = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_rd_n_wr,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [DATA_W-1:0] i_req_wdata,
   output logic              o_rsp_valid,
   input  logic              i_rsp_ready,
   output logic [DATA_W-1:0] o_rsp_rdata,
   output logic              o_eng_valid,
   input  logic              i_eng_accept,
   output logic              o_eng_rd_n_wr,
   output logic [ADDR_W-1:0] o_eng_addr,
   output logic [DATA_W-1:0] o_eng_wdata,
   input  logic              i_eng_ready,
   input  logic [DATA_W-1:0] i_eng_rdata,
   output logic              o_busy
);

`ifdef X23K640_RDATA_FIFO_EN
   localparam bit RdataFifoEn = 1'b1;
`else
   localparam bit RdataFifoEn = 1'b0;
`endif
   localparam int unsigned Cap  = RdataFifoEn ? RSP_DEPTH : 1;
   localparam int unsigned CntW = $clog2(Cap) + 1;
   localparam int unsigned OccW = CntW + 1;

   req_t                       req_in, req_head;
   logic                       req_full, req_empty, req_push, eng_pop, rd_issue;
   logic [$clog2(REQ_DEPTH):0] req_count;
   logic [CntW-1:0]            outstanding_q, outstanding_d;
   logic [CntW-1:0]            rsp_count;
   logic [OccW-1:0]            occ;
   logic                       credit_ok, rsp_pop;

   assign req_in      = '{rd_n_wr: i_req_rd_n_wr, addr: i_req_addr, wdata: i_req_wdata};
   assign o_req_ready = ~req_full;
   assign req_push    = i_req_valid & o_req_ready;

   x_23k640_req_fifo #(
      .WIDTH (REQ_W),
      .DEPTH (REQ_DEPTH)
   ) u_req_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (req_push),
      .i_wdata (req_in),
      .i_pop   (eng_pop),
      .o_rdata (req_head),
      .o_full  (req_full),
      .o_empty (req_empty),
      .o_count (req_count)
   );

   // Reads only go out when the response side can absorb every completion already in flight.
   assign occ         = OccW'(rsp_count) + OccW'(outstanding_q);
   assign credit_ok   = occ < OccW'(Cap);
   assign o_eng_valid = ~req_empty & (~req_head.rd_n_wr | credit_ok);
   assign eng_pop     = i_eng_accept & o_eng_valid;
   assign rd_issue    = eng_pop & req_head.rd_n_wr;

   assign o_eng_rd_n_wr = req_head.rd_n_wr;
   assign o_eng_addr    = req_head.addr;
   assign o_eng_wdata   = req_head.wdata;

   always_comb begin
      outstanding_d = outstanding_q;
      if (rd_issue && !i_eng_ready) begin
         outstanding_d = outstanding_q + CntW'(1);
      end else if (!rd_issue && i_eng_ready && (outstanding_q != '0)) begin
         outstanding_d = outstanding_q - CntW'(1);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) outstanding_q <= '0;
      else       outstanding_q <= outstanding_d;
   end

   assign rsp_pop = o_rsp_valid & i_rsp_ready;

`ifdef X23K640_RDATA_FIFO_EN
   logic rsp_full, rsp_empty;

   x_23k640_req_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (i_eng_ready),
      .i_wdata (i_eng_rdata),
      .i_pop   (rsp_pop),
      .o_rdata (o_rsp_rdata),
      .o_full  (rsp_full),
      .o_empty (rsp_empty),
      .o_count (rsp_count)
   );

   assign o_rsp_valid = ~rsp_empty;

   a_rsp_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
      i_eng_ready |-> !rsp_full);
`else
   logic              rsp_valid_q;
   logic [DATA_W-1:0] rsp_data_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else if (i_eng_ready) begin
         rsp_valid_q <= 1'b1;
         rsp_data_q  <= i_eng_rdata;
      end else if (rsp_pop) begin
         rsp_valid_q <= 1'b0;
      end
   end

   assign rsp_count   = CntW'(rsp_valid_q);
   assign o_rsp_valid = rsp_valid_q;
   assign o_rsp_rdata = rsp_data_q;

   a_rsp_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
      i_eng_ready |-> !rsp_valid_q || rsp_pop);
`endif

   assign o_busy = (req_count != '0) | (outstanding_q != '0) | (rsp_count != '0);

   a_accept_valid: assert property (@(posedge i_clk) disable iff (i_rst)
      i_eng_accept |-> o_eng_valid);
   a_ready_outstanding: assert property (@(posedge i_clk) disable iff (i_rst)
      i_eng_ready |-> outstanding_q != '0);
   a_head_stable: assert property (@(posedge i_clk) disable iff (i_rst)
      o_eng_valid && !i_eng_accept |=> o_eng_valid && $stable(req_head));

endmodule

// File: tb/tb_x_23k640_req.sv
// Scoreboard bench for x_23k640_req; honours X23K640_RDATA_FIFO_EN for expected issue counts.
module tb_x_23k640_req;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_rd;
   logic [15:0] req_addr;
   logic [7:0]  req_wdata;
   logic        rsp_valid, rsp_ready;
   logic [7:0]  rsp_rdata;
   logic        eng_valid, eng_accept, eng_rd;
   logic [15:0] eng_addr;
   logic [7:0]  eng_wdata;
   logic        eng_ready;
   logic [7:0]  eng_rdata;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   logic [24:0] exp_req[$];
   logic [7:0]  exp_rsp[$];
   logic [7:0]  eng_q[$];
   logic [24:0] mon_req;
   logic [7:0]  mon_rsp;

   always #5 clk = ~clk;

   x_23k640_req dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_req_valid   (req_valid),
      .o_req_ready   (req_ready),
      .i_req_rd_n_wr (req_rd),
      .i_req_addr    (req_addr),
      .i_req_wdata   (req_wdata),
      .o_rsp_valid   (rsp_valid),
      .i_rsp_ready   (rsp_ready),
      .o_rsp_rdata   (rsp_rdata),
      .o_eng_valid   (eng_valid),
      .i_eng_accept  (eng_accept),
      .o_eng_rd_n_wr (eng_rd),
      .o_eng_addr    (eng_addr),
      .o_eng_wdata   (eng_wdata),
      .i_eng_ready   (eng_ready),
      .i_eng_rdata   (eng_rdata),
      .o_busy        (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: DUT handshake with empty scoreboard queue", name);
   endtask

   // Monitor: compares every engine hand-off and every response hand-off against the queues.
   always @(negedge clk) begin
      if (!rst) begin
         if (eng_valid && eng_accept) begin
            if (exp_req.size() == 0) fail_now("eng_req_unexpected");
            else begin
               mon_req = exp_req.pop_front();
               check("eng_req", {7'b0, eng_rd, eng_addr, eng_wdata}, {7'b0, mon_req});
            end
         end
         if (rsp_valid && rsp_ready) begin
            if (exp_rsp.size() == 0) fail_now("rsp_unexpected");
            else begin
               mon_rsp = exp_rsp.pop_front();
               check("rsp_rdata", {24'b0, rsp_rdata}, {24'b0, mon_rsp});
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; for reads d is the data the engine will return.
   task automatic offer(input bit rd, input logic [15:0] a, input logic [7:0] d, output bit took);
      req_valid = 1'b1;
      req_rd    = rd;
      req_addr  = a;
      req_wdata = d;
      @(negedge clk);
      took = req_ready;
      tick();
      req_valid = 1'b0;
      if (took) begin
         exp_req.push_back({rd, a, d});
         if (rd) begin
            exp_rsp.push_back(d);
            eng_q.push_back(d);
         end
      end
   endtask

   task automatic accept_one();
      eng_accept = 1'b1;
      tick();
      eng_accept = 1'b0;
   endtask

   task automatic engine_run(input int cycles, output int issued);
      bit pend = 1'b0;
      issued = 0;
      for (int i = 0; i < cycles; i++) begin
         eng_ready = pend;
         if (pend && eng_q.size() > 0) eng_rdata = eng_q.pop_front();
         eng_accept = eng_valid;
         if (eng_valid) issued++;
         pend = eng_valid && eng_rd;
         tick();
      end
      eng_accept = 1'b0;
      eng_ready  = pend;
      if (pend && eng_q.size() > 0) eng_rdata = eng_q.pop_front();
      tick();
      eng_ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit took;
      int issued;
      rst = 1'b1;
      req_valid = 0; req_rd = 0; req_addr = '0; req_wdata = '0;
      rsp_ready = 0; eng_accept = 0; eng_ready = 0; eng_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      // 1: reset state
      check("rst_req_ready", req_ready, 1);
      check("rst_eng_valid", eng_valid, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_eng_addr", eng_addr, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      rst = 1'b0;
      tick();

      // 2: single write
      offer(1'b0, 16'h0010, 8'hA5, took);
      check("wr_took", took, 1);
      @(negedge clk);
      check("wr_eng_valid", eng_valid, 1);
      check("wr_eng_addr", eng_addr, 16'h0010);
      check("wr_eng_wdata", eng_wdata, 8'hA5);
      check("wr_eng_rd", eng_rd, 0);
      tick();
      accept_one();
      @(negedge clk);
      check("wr_done_valid", eng_valid, 0);
      check("wr_no_rsp", rsp_valid, 0);
      check("wr_done_busy", busy, 0);
      tick();

      // 3: fill request FIFO, fifth request refused
      for (int i = 0; i < 5; i++) begin
         offer(1'b0, 16'h0020 + 16'(i), 8'h10 + 8'(i), took);
         check("fill_took", took, (i < 4) ? 1 : 0);
      end
      @(negedge clk);
      check("full_ready", req_ready, 0);
      check("full_head", eng_addr, 16'h0020);
      tick();
      accept_one();
      @(negedge clk);
      check("after_pop_ready", req_ready, 1);
      tick();
      repeat (3) accept_one();
      @(negedge clk);
      check("drain_valid", eng_valid, 0);
      check("drain_busy", busy, 0);
      tick();

      // 4: two reads, completion order and one-cycle latency
      offer(1'b1, 16'h0100, 8'h3C, took);
      offer(1'b1, 16'h0101, 8'hC3, took);
      rsp_ready = 1'b1;
      eng_q.delete();
`ifdef X23K640_RDATA_FIFO_EN
      eng_accept = 1'b1;                            // accept #1
      tick();
      eng_ready = 1'b1; eng_rdata = 8'h3C;          // accept #2 with ready #1
      @(negedge clk);
      check("rd2_eng_valid", eng_valid, 1);
      check("rd1_rsp_latency", rsp_valid, 0);
      tick();
      eng_accept = 1'b0; eng_rdata = 8'hC3;         // ready #2
      @(negedge clk);
      check("rd1_rsp_valid", rsp_valid, 1);
      check("rd1_rsp_data", rsp_rdata, 8'h3C);
      check("rd_busy", busy, 1);
      tick();
      eng_ready = 1'b0;
      @(negedge clk);
      check("rd2_rsp_valid", rsp_valid, 1);
      check("rd2_rsp_data", rsp_rdata, 8'hC3);
      tick();
`else
      eng_accept = 1'b1;
      tick();
      eng_accept = 1'b0; eng_ready = 1'b1; eng_rdata = 8'h3C;
      @(negedge clk);
      check("rd2_held_valid", eng_valid, 0);
      check("rd1_rsp_latency", rsp_valid, 0);
      tick();
      eng_ready = 1'b0;
      @(negedge clk);
      check("rd1_rsp_valid", rsp_valid, 1);
      check("rd1_rsp_data", rsp_rdata, 8'h3C);
      check("rd2_unconsumed_hold", eng_valid, 0);
      tick();
      eng_accept = 1'b1;
      @(negedge clk);
      check("rd2_eng_addr", eng_addr, 16'h0101);
      tick();
      eng_accept = 1'b0; eng_ready = 1'b1; eng_rdata = 8'hC3;
      @(negedge clk);
      check("rd2_rsp_latency", rsp_valid, 0);
      tick();
      eng_ready = 1'b0;
      @(negedge clk);
      check("rd2_rsp_valid", rsp_valid, 1);
      check("rd2_rsp_data", rsp_rdata, 8'hC3);
      tick();
`endif
      @(negedge clk);
      check("rd_idle_rsp", rsp_valid, 0);
      check("rd_idle_busy", busy, 0);
      tick();

      // 5: stalled consumer limits issued reads to the response capacity
      rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++) offer(1'b1, 16'h0200 + 16'(i), 8'h50 + 8'(i), took);
      engine_run(10, issued);
`ifdef X23K640_RDATA_FIFO_EN
      check("stall_issued", issued, 4);
`else
      check("stall_issued", issued, 1);
`endif
      @(negedge clk);
      check("stall_eng_valid", eng_valid, 0);
      check("stall_rsp_valid", rsp_valid, 1);
      check("stall_rsp_head", rsp_rdata, 8'h50);
      check("stall_busy", busy, 1);
      tick();
      rsp_ready = 1'b1;
      engine_run(20, issued);
      @(negedge clk);
      check("release_busy", busy, 0);
      check("release_rsp_left", exp_rsp.size(), 0);
      tick();

      // 6: asynchronous reset with reads queued and one outstanding
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) offer(1'b1, 16'h0300 + 16'(i), 8'h70 + 8'(i), took);
      accept_one();
      rst = 1'b1;
      #1;
      check("arst_req_ready", req_ready, 1);
      check("arst_eng_valid", eng_valid, 0);
      check("arst_rsp_valid", rsp_valid, 0);
      check("arst_busy", busy, 0);
      check("arst_eng_addr", eng_addr, 0);
      check("arst_eng_wdata", eng_wdata, 0);
      exp_req.delete();
      exp_rsp.delete();
      eng_q.delete();
      tick();
      rst = 1'b0;
      tick();
      offer(1'b0, 16'h0444, 8'h5A, took);
      @(negedge clk);
      check("post_rst_head", eng_addr, 16'h0444);
      tick();
      accept_one();
      @(negedge clk);
      check("post_rst_busy", busy, 0);
      check("final_req_left", exp_req.size(), 0);
      check("final_rsp_left", exp_rsp.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
